rv32_mod_muldiv: RTL and testbench
==================================

# rv32_mod_muldiv

Iterative RV32M multiply/divide unit next to the single-cycle integer ALU in the execute stage. It accepts one M-extension operation (funct3-encoded), runs a 32-iteration shift-add multiply or restoring divide on operand magnitudes, applies sign correction, and returns a 32-bit result with a one-cycle `done` pulse. The execute stage holds the pipeline while `busy` is high.

## Interface
- `DIV_ZERO_SHORTCUT`, default 1: when 1, divide-by-zero skips iteration and completes one cycle after acceptance; when 0, it runs the full sequence with the same result.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request; sampled only in IDLE.
- `kill` in 1: abort the current operation (pipeline flush).
- `func` in 3: funct3. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `read0_data` in 32: rs1 operand.
- `read1_data` in 32: rs2 operand.
- `busy` out 1: an operation is in flight (any state except IDLE).
- `done` out 1: one-cycle pulse; `result` is valid in that cycle.
- `result` out 32: result register, held until the next accepted `start`.

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - `start`=1 latches `func` and both operands, records the sign flags, stores magnitudes, clears the 64-bit accumulator and the 5-bit counter, then goes to CALC.
  - With divide-by-zero and `DIV_ZERO_SHORTCUT`=1, it goes straight to DONE.
- CALC, one iteration per cycle, counter 0..31:
  - Multiply: add the multiplicand to the upper accumulator half when the multiplier LSB is 1, then shift right.
  - Divide: shift the remainder left by 1, take in the next dividend bit, trial-subtract the divisor, and keep the difference if non-negative. The quotient bit is 1 on success.
  - When the counter reaches 31, go to FIXUP.
- FIXUP: negate the product, quotient or remainder per the sign rules, select the output word, write `result`, then go to DONE.
- DONE: `done`=1 for exactly this cycle, then go to IDLE.
- Signedness:
  - MUL and MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - DIV and REM: signed.
- Sign rules:
  - The product is negated when the operand signs differ.
  - The quotient is negated when the signs differ.
  - The remainder takes the sign of the dividend.
- Output selection: MUL takes product[31:0]; MULH, MULHSU and MULHU take product[63:32].
- Divide by zero: quotient is 0xFFFFFFFF (signed and unsigned), remainder is the dividend.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0. The magnitude path produces this with no special case.
- `start` outside IDLE is ignored; requesters hold it until they see `done`.
- `kill` in any state returns to IDLE at the next edge. No `done` is produced, `result` is unchanged, and `kill` has priority over `start` in IDLE.
- `rst` has priority over everything:
  - State goes to IDLE and the counter to 0.
  - Outputs reset to `busy`=0, `done`=0 and `result`=0.

## Timing
- Start accepted at edge E0:
  - CALC occupies cycles 1–32.
  - FIXUP is cycle 33.
  - DONE is cycle 34: `done`=1, `result` valid.
  - IDLE from cycle 35; a new start can be accepted at the end of cycle 35.
- Shortcut divide-by-zero: DONE is cycle 1, with `result` written at E0.
- `busy` is registered: high from cycle 1 through the DONE cycle inclusive.
- All outputs are registered and have no combinational path from inputs.

## Structure
- Shared package `rv32_pkg`:
  - `muldiv_op_e`, the funct3 enum.
  - `muldiv_state_e`.
  - Constant `MULDIV_ITERS`=32.
- Natural sub-module `rv32_mod_abs_neg`: combinational conditional two's-complement of a 64-bit value with an enable. It is used for operand magnitudes and result fixup.
- The counter, FSM and accumulator live in the top module.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) → `done` at cycle 34, `result` 0xFFFFFFEB. `busy` is high for cycles 1–34.
- MULH, MULHSU and MULHU with 0x80000000 × 0xFFFFFFFF → 0x00000000, 0x80000000 and 0x7FFFFFFF respectively.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- Divide by zero:
  - DIVU 5 / 0 → 0xFFFFFFFF with `done` at cycle 1 (shortcut).
  - REM 5 / 0 → 5.
  - With `DIV_ZERO_SHORTCUT`=0 → `done` at cycle 34 with the same values.
- Interruptions:
  - `kill` at cycle 10 → IDLE at cycle 11, no `done`, `result` keeps its prior value.
  - `start` asserted while busy → ignored.
  - `rst` at cycle 20 → `busy`, `done` and `result` are all 0 the next cycle.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the execute-stage M-extension unit:
// funct3 encodings, FSM states, iteration count and small decode helpers.
package rv32_pkg;

  // funct3 encoding of the M-extension operations.
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } muldiv_state_e;

  localparam int MULDIV_ITERS = 32;
  localparam int MULDIV_CNT_W = $clog2(MULDIV_ITERS);

  // Divide and remainder operations all have funct3[2] set.
  function automatic logic op_is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  // REM and REMU return the remainder rather than the quotient.
  function automatic logic op_is_rem(input muldiv_op_e op);
    return op[2] & op[1];
  endfunction

  // MULH, MULHSU and MULHU return the upper product word.
  function automatic logic op_mul_high(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

  // rs1 is treated as signed for MUL, MULH, MULHSU, DIV and REM.
  function automatic logic op_rs1_signed(input muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as signed for MUL, MULH, DIV and REM.
  function automatic logic op_rs2_signed(input muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/rv32_mod_abs_neg.sv
// Conditional two's-complement negation. Used both to take operand
// magnitudes before iteration and to restore the result sign afterwards.
module rv32_mod_abs_neg #(
  parameter int W = 64
) (
  input  logic         en_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] val_o
);

  // Negate when enabled, pass through otherwise.
  always_comb begin
    val_o = en_i ? (~val_i + W'(1)) : val_i;
  end

endmodule

// File: rtl/rv32_mod_muldiv.sv
// Iterative RV32M multiply/divide unit. One operation at a time: operand
// magnitudes are captured on start, 32 shift-add or restoring-divide steps
// run in CALC, the sign is restored in FIXUP and DONE pulses `done`.
module rv32_mod_muldiv
  import rv32_pkg::*;
#(
  parameter bit DIV_ZERO_SHORTCUT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        kill,
  input  logic [2:0]  func,
  input  logic [31:0] read0_data,
  input  logic [31:0] read1_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  // Control state (reset).
  muldiv_state_e           state_q, state_d;
  logic [MULDIV_CNT_W-1:0] cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [31:0]             result_q, result_d;

  // Datapath state (captured on start, meaningless while idle).
  muldiv_op_e              op_q, op_d;
  logic                    neg_q, neg_d;     // negate the selected result in FIXUP
  logic [31:0]             opa_q, opa_d;     // multiplier / dividend magnitude
  logic [31:0]             opb_q, opb_d;     // multiplicand / divisor magnitude
  logic [63:0]             acc_q, acc_d;     // product, or {remainder, quotient}

  // Request decode.
  muldiv_op_e  func_op;
  logic        sign_a;
  logic        sign_b;
  logic        div_zero;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

  // Iteration datapath.
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ok;
  logic [31:0] div_rem;

  // Sign fixup datapath.
  logic [63:0] fix_in;
  logic [63:0] fix_out;
  logic [31:0] fix_word;

  assign func_op  = muldiv_op_e'(func);
  assign sign_a   = op_rs1_signed(func_op) & read0_data[31];
  assign sign_b   = op_rs2_signed(func_op) & read1_data[31];
  assign div_zero = (read1_data == 32'd0);

  rv32_mod_abs_neg #(.W(32)) u_abs_a (
    .en_i  (sign_a),
    .val_i (read0_data),
    .val_o (mag_a)
  );

  rv32_mod_abs_neg #(.W(32)) u_abs_b (
    .en_i  (sign_b),
    .val_i (read1_data),
    .val_o (mag_b)
  );

  // One multiply step: conditionally add the multiplicand to the upper half;
  // one divide step: shift in the next dividend bit and trial-subtract.
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (opa_q[0] ? {1'b0, opb_q} : 33'd0);
    div_shift = {acc_q[63:32], opa_q[31]};
    div_ok    = (div_shift >= {1'b0, opb_q});
    // The remainder stays below the divisor, so 32 bits hold the difference.
    div_rem   = div_ok ? (div_shift[31:0] - opb_q) : div_shift[31:0];
  end

  // Pick the raw magnitude to sign-correct: product, quotient or remainder.
  always_comb begin
    if (op_is_div(op_q)) begin
      fix_in = op_is_rem(op_q) ? {32'd0, acc_q[63:32]} : {32'd0, acc_q[31:0]};
    end else begin
      fix_in = acc_q;
    end
  end

  rv32_mod_abs_neg #(.W(64)) u_fixup (
    .en_i  (neg_q),
    .val_i (fix_in),
    .val_o (fix_out)
  );

  assign fix_word = op_mul_high(op_q) ? fix_out[63:32] : fix_out[31:0];

  // Next-state, datapath and output logic.
  always_comb begin
    // NOTE: every _d gets a default before the case so no path can leave a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    op_d     = op_q;
    neg_d    = neg_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d  = func_op;
          opa_d = mag_a;
          opb_d = mag_b;
          acc_d = 64'd0;
          cnt_d = '0;
          if (op_is_div(func_op)) begin
            // A zero divisor yields an all-ones quotient regardless of signs.
            neg_d = op_is_rem(func_op) ? sign_a : ((sign_a ^ sign_b) & ~div_zero);
          end else begin
            neg_d = sign_a ^ sign_b;
          end
          if (DIV_ZERO_SHORTCUT && op_is_div(func_op) && div_zero) begin
            result_d = op_is_rem(func_op) ? read0_data : 32'hFFFF_FFFF;
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        if (op_is_div(op_q)) begin
          acc_d = {div_rem, acc_q[30:0], div_ok};
          opa_d = {opa_q[30:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
          opa_d = {1'b0, opa_q[31:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == MULDIV_CNT_W'(MULDIV_ITERS - 1)) begin
          state_d = ST_FIXUP;
        end
      end

      ST_FIXUP: begin
        result_d = fix_word;
        state_d  = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A flush abandons the operation without touching the visible result.
    if (kill) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples its pre-edge inputs.
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // Datapath registers, always loaded before use.
  always_ff @(posedge clk) begin
    // NOTE: no reset here; these are fully written on every accepted start.
    op_q  <= op_d;
    neg_q <= neg_d;
    opa_q <= opa_d;
    opb_q <= opb_d;
    acc_q <= acc_d;
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_rv32_mod_muldiv.sv
// Self-checking bench for rv32_mod_muldiv. Two instances share operands:
// u_dut uses the divide-by-zero shortcut, u_dut_ns runs the full sequence.
// Expected results go into a scoreboard when an operation is issued and are
// compared when `done` appears.
module tb_rv32_mod_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        start_b;
  logic        kill;
  logic [2:0]  func;
  logic [31:0] rs1;
  logic [31:0] rs2;

  logic        busy,   done;
  logic [31:0] result;
  logic        busy_b, done_b;
  logic [31:0] result_b;

  rv32_mod_muldiv #(.DIV_ZERO_SHORTCUT(1'b1)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .kill       (kill),
    .func       (func),
    .read0_data (rs1),
    .read1_data (rs2),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  rv32_mod_muldiv #(.DIV_ZERO_SHORTCUT(1'b0)) u_dut_ns (
    .clk        (clk),
    .rst        (rst),
    .start      (start_b),
    .kill       (kill),
    .func       (func),
    .read0_data (rs1),
    .read1_data (rs2),
    .busy       (busy_b),
    .done       (done_b),
    .result     (result_b)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [31:0] exp;
    int          lat;
    int          n;
    bit          inst_b;
  } item_t;

  item_t       sb[$];
  item_t       mon_it;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_a   = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model of the RV32M operations.
  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb_ = longint'($signed(b));
    longint      ua = longint'({32'd0, a});
    longint      ub = longint'({32'd0, b});
    logic [63:0] p;
    logic [31:0] r;
    case (f)
      3'd0: begin p = 64'(sa * sb_); r = p[31:0];  end
      3'd1: begin p = 64'(sa * sb_); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub);  r = p[63:32]; end
      3'd3: begin p = 64'(ua * ub);  r = p[63:32]; end
      3'd4: begin p = 64'(sa / sb_); r = (b == 0) ? 32'hFFFF_FFFF : p[31:0]; end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin p = 64'(sa % sb_); r = (b == 0) ? a : p[31:0]; end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done || done_b) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_it = sb.pop_front();
        check("result", done_b ? result_b : result, mon_it.exp);
        check("latency", 32'(edge_cnt - mon_it.n), 32'(mon_it.lat));
        check("done_instance", {31'd0, done_b}, {31'd0, mon_it.inst_b});
      end
    end
  end

  // Issue one operation, hold start until done, check busy span.
  // perturb changes func/operands mid-flight to show they are ignored.
  task automatic do_op(input bit use_b, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit perturb);
    item_t it;
    bit    seen;
    int    busy_cnt;
    int    lat;
    lat = (!use_b && f[2] && (b == 32'd0)) ? 1 : 34;
    @(posedge clk); #1;
    func = f;
    rs1  = a;
    rs2  = b;
    it.exp    = exp;
    it.lat    = lat;
    it.n      = edge_cnt;
    it.inst_b = use_b;
    sb.push_back(it);
    if (use_b) start_b = 1'b1;
    else       start   = 1'b1;
    seen     = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (use_b ? busy_b : busy) busy_cnt++;
      if (use_b ? done_b : done) seen = 1'b1;
      if (perturb && i == 4) begin
        func = ~f;
        rs1  = ~a;
        rs2  = b ^ 32'h5A5A_0F0F;
      end
    end
    start   = 1'b0;
    start_b = 1'b0;
    check("done_seen", {31'd0, seen}, 32'd1);
    check("busy_cycles", 32'(busy_cnt), 32'(lat));
    @(negedge clk);
    check("busy_after_done", {31'd0, use_b ? busy_b : busy}, 32'd0);
    if (!use_b) last_a = exp;
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; start_b = 1'b0; kill = 1'b0;
    func = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",     {31'd0, busy},   32'd0);
    check("rst_done",     {31'd0, done},   32'd0);
    check("rst_result",   result,          32'd0);
    check("rst_busy_b",   {31'd0, busy_b}, 32'd0);
    check("rst_result_b", result_b,        32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Multiply family.
    do_op(1'b0, 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    do_op(1'b0, 3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    do_op(1'b0, 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    do_op(1'b0, 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0);

    // Divide family.
    do_op(1'b0, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    do_op(1'b0, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    do_op(1'b0, 3'b101, 32'd100, 32'd7, 32'd14, 1'b0);
    do_op(1'b0, 3'b111, 32'd100, 32'd7, 32'd2, 1'b0);
    do_op(1'b0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    do_op(1'b0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);

    // Divide by zero, shortcut and full-length.
    do_op(1'b0, 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    do_op(1'b0, 3'b110, 32'd5, 32'd0, 32'd5, 1'b0);
    do_op(1'b0, 3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b0);
    do_op(1'b0, 3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b0);
    do_op(1'b1, 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    do_op(1'b1, 3'b110, 32'd5, 32'd0, 32'd5, 1'b0);
    do_op(1'b1, 3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b0);
    do_op(1'b1, 3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b0);

    // Inputs changing while busy must not affect the operation in flight.
    do_op(1'b0, 3'b011, 32'hDEAD_BEEF, 32'h1234_5678,
          ref_md(3'b011, 32'hDEAD_BEEF, 32'h1234_5678), 1'b1);

    // Random operations against the reference model.
    for (int i = 0; i < 8; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i == 3) ? 32'd3 : $urandom;
      do_op(1'b0, rf, ra, rb, ref_md(rf, ra, rb), 1'b0);
    end

    // Kill during cycle 10: idle at cycle 11, no done, result unchanged.
    @(posedge clk); #1;
    func = 3'b000; rs1 = 32'd11; rs2 = 32'd13; start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    kill = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    kill = 1'b0;
    @(negedge clk);
    check("kill_busy",   {31'd0, busy}, 32'd0);
    check("kill_done",   {31'd0, done}, 32'd0);
    check("kill_result", result, last_a);
    repeat (40) @(negedge clk);
    check("kill_result_late", result, last_a);

    // Kill has priority over start in IDLE.
    @(posedge clk); #1;
    func = 3'b101; rs1 = 32'd9; rs2 = 32'd0; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    @(negedge clk);
    check("kill_vs_start_busy", {31'd0, busy}, 32'd0);
    check("kill_vs_start_result", result, last_a);

    // Reset during cycle 20: everything cleared the next cycle.
    @(posedge clk); #1;
    func = 3'b100; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("rst_mid_busy",   {31'd0, busy}, 32'd0);
    check("rst_mid_done",   {31'd0, done}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_a = 32'd0;

    // Recovery after reset.
    do_op(1'b0, 3'b000, 32'h0001_0001, 32'h0000_FFFF, 32'hFFFF_FFFF, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
